// File: rtl/top_level_dec_if.sv
// ----------------------------------------------------------------------------
// top_level_dec_if
// Request/response bundle for the modular-exponentiation decryptor.
//   start    : request; an operation is accepted on a rising edge
//   c        : ciphertext, sampled in the accept cycle
//   d_key    : private exponent, sampled in the accept cycle
//   n        : modulus, sampled in the accept cycle
//   message  : recovered plaintext c^d_key mod n, valid while done=1
//   done     : level, high from completion until the next accept or reset
//   err      : level, high together with done when the operands were illegal
// master = requester (drives operands), slave = decryptor.
// ----------------------------------------------------------------------------
interface top_level_dec_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d_key;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] message;
    logic             done;
    logic             err;

    modport master (
        output start, c, d_key, n,
        input  message, done, err
    );

    modport slave (
        input  start, c, d_key, n,
        output message, done, err
    );
endinterface

// File: rtl/top_level_dec.sv
// ----------------------------------------------------------------------------
// top_level_dec
// Computes message = c^d_key mod n by MSB-first square-and-multiply. Every
// modular multiply is an interleaved shift-add that consumes one multiplier
// bit per cycle, MSB first, so each multiply takes exactly WIDTH cycles.
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : top_level_dec_if.slave (start, c, d_key, n, message, done, err)
//
// Build option:
//   CONST_TIME_EN : when defined, all WIDTH exponent bits are processed and
//                   a multiply runs for every bit (its result is dropped for
//                   0 bits), giving a data-independent latency of
//                   1 + 2*WIDTH*WIDTH cycles. When undefined, processing
//                   starts at the highest set exponent bit and multiplies
//                   only run for 1 bits.
// ----------------------------------------------------------------------------
module top_level_dec #(
    parameter int WIDTH = 128
) (
    input  logic            clk,
    input  logic            reset,
    top_level_dec_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

`ifdef CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } state_t;

    state_t           state_q,   state_d;
    logic             start_q,   start_d;
    logic [WIDTH-1:0] c_q,       c_d;
    logic [WIDTH-1:0] d_q,       d_d;
    logic [WIDTH-1:0] n_q,       n_d;
    logic [WIDTH-1:0] acc_q,     acc_d;      // committed result, always < n
    logic [WIDTH-1:0] prod_q,    prod_d;     // running product of current multiply
    logic [CW-1:0]    cnt_q,     cnt_d;      // multiplier bit index, WIDTH-1 .. 0
    logic [CW-1:0]    ebit_q,    ebit_d;     // exponent bit index being processed
    logic [WIDTH-1:0] message_q, message_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic [CW-1:0]    ebit_init;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] commit_val;

    // One interleaved shift-add step. The intermediate is WIDTH+1 bits wide:
    // 2R < 2n and (R mod n) + multiplicand < 2n both fit without overflow,
    // and the returned value is always < n, so stored products stay WIDTH bits.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] r,
        input logic             mbit,
        input logic [WIDTH-1:0] mc,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] mm;
        mm = {1'b0, m};
        t  = {r, 1'b0};
        if (t >= mm) t = t - mm;
        if (mbit)    t = t + {1'b0, mc};
        if (t >= mm) t = t - mm;
        return t[WIDTH-1:0];
    endfunction

    // Starting exponent bit.
`ifdef CONST_TIME_EN
    assign ebit_init = CW'(WIDTH - 1);
`else
    always_comb begin
        ebit_init = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d_q[i]) ebit_init = CW'(i);
        end
    end
`endif

    // Squaring multiplies acc by itself; the multiply step multiplies acc by c.
    // In both cases the multiplier bits are taken from acc, which stays
    // constant for the whole multiply because results go to prod first.
    assign mcand    = (state_q == MUL) ? c_q : acc_q;
    assign step_val = mod_step(prod_q, acc_q[cnt_q], mcand, n_q);

    // A multiply result for a 0 exponent bit only exists in the constant-time
    // build and is dropped there; squares always commit.
    assign commit_val = (state_q == MUL && !d_q[ebit_q]) ? acc_q : step_val;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        start_d   = bus.start;
        c_d       = c_q;
        d_d       = d_q;
        n_d       = n_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        ebit_d    = ebit_q;
        message_d = message_q;
        done_d    = done_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE, DONE: begin
                // Start edges are only honoured here; busy states ignore them.
                if (bus.start && !start_q) begin
                    c_d       = bus.c;
                    d_d       = bus.d_key;
                    n_d       = bus.n;
                    message_d = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                acc_d  = WIDTH'(1);
                prod_d = '0;
                cnt_d  = CW'(WIDTH - 1);
                ebit_d = ebit_init;
                if (n_q <= WIDTH'(1) || c_q >= n_q) begin
                    message_d = '0;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (!CONST_TIME && d_q == '0) begin
                    message_d = WIDTH'(1);
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = SQR;
                end
            end

            SQR, MUL: begin
                prod_d = step_val;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    acc_d  = commit_val;
                    prod_d = '0;
                    cnt_d  = CW'(WIDTH - 1);
                    if (state_q == SQR && (CONST_TIME || d_q[ebit_q])) begin
                        state_d = MUL;
                    end else if (ebit_q == '0) begin
                        message_d = commit_val;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        ebit_d  = ebit_q - 1'b1;
                        state_d = SQR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            c_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            ebit_q    <= '0;
            message_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            c_q       <= c_d;
            d_q       <= d_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            ebit_q    <= ebit_d;
            message_q <= message_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.message = message_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_top_level_dec.sv
// ----------------------------------------------------------------------------
// tb_top_level_dec
// Self-checking bench for top_level_dec. Expected plaintexts come from a
// right-to-left binary exponentiation on 64-bit integers; expected latencies
// come from the closed-form cycle counts. The constant-time build uses a
// narrower WIDTH so its 1+2*WIDTH^2 latency stays short.
// ----------------------------------------------------------------------------
module tb_top_level_dec;

`ifdef CONST_TIME_EN
    localparam int  W          = 16;
    localparam bit  CONST_TIME = 1'b1;
`else
    localparam int  W          = 128;
    localparam bit  CONST_TIME = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    top_level_dec_if #(.WIDTH(W)) bus ();

    top_level_dec #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: c^d mod n, or err for illegal operands.
    function automatic longint ref_pow(input longint b, input longint e, input longint m);
        longint r = 1;
        b = b % m;
        while (e > 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >>> 1;
        end
        return r;
    endfunction

    function automatic bit ref_illegal(input longint c, input longint m);
        return (m <= 1) || (c >= m);
    endfunction

    function automatic int ref_latency(input longint c, input longint d, input longint m);
        int k;
        int p;
        if (ref_illegal(c, m)) return 1;
        if (CONST_TIME) return 1 + 2 * W * W;
        k = $clog2(d + 1);
        p = $countones(d);
        return 1 + W * (k + p);
    endfunction

    function automatic longint ref_msg(input longint c, input longint d, input longint m);
        if (ref_illegal(c, m)) return 0;
        return ref_pow(c, d, m);
    endfunction

    // Waits from the accept edge until done, then checks latency/result.
    // With disturb set, start is toggled and operands are scrambled while busy.
    task automatic wait_done(input string tag, input longint c, input longint d,
                             input longint m, input bit disturb);
        int cyc = 0;
        int lat = ref_latency(c, d, m);
        bit seen = 1'b0;
        while (!seen && cyc < lat + 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.done) begin
                seen = 1'b1;
            end else if (disturb && cyc == 5) begin
                bus.start = 1'b0;
            end else if (disturb && cyc == 6) begin
                bus.start = 1'b1;
                bus.c     = W'($urandom_range(0, 65535));
                bus.d_key = W'($urandom_range(0, 4095));
                bus.n     = W'($urandom_range(2, 65535));
            end
        end
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_message"}, 128'(bus.message), 128'(ref_msg(c, d, m)));
        check({tag, "_err"}, 128'(bus.err), 128'(ref_illegal(c, m)));
    endtask

    // Issue a start edge with fresh operands and check the accept cycle.
    task automatic start_op(input string tag, input longint c, input longint d, input longint m);
        @(negedge clk);
        if (bus.start) begin
            bus.start = 1'b0;
            @(negedge clk);
        end
        bus.c     = W'(c);
        bus.d_key = W'(d);
        bus.n     = W'(m);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_accept_done_clear"}, 128'(bus.done), 128'(0));
    endtask

    task automatic run_op(input string tag, input longint c, input longint d,
                          input longint m, input bit disturb);
        start_op(tag, c, d, m);
        wait_done(tag, c, d, m, disturb);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [127:0] held;
        longint rc, rd, rn;

        // Reset with start already high: accept must follow reset release.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.c     = W'(948);
        bus.d_key = W'(157);
        bus.n     = W'(2773);
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 128'(bus.done), 128'(0));
        check("reset_err", 128'(bus.err), 128'(0));
        check("reset_message", 128'(bus.message), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_accept_done", 128'(bus.done), 128'(0));
        wait_done("decrypt_948", 948, 157, 2773, 1'b0);

        // start still high after done: no restart, result holds.
        held = 128'(bus.message);
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", 128'(bus.done), 128'(1));
        check("hold_message", 128'(bus.message), held);
        check("hold_message_value", 128'(bus.message), 128'(920));

        // Round trip and trivial bases.
        run_op("encrypt_920", 920, 17, 2773, 1'b0);
        run_op("decrypt_again", 948, 157, 2773, 1'b0);
        run_op("base_zero", 0, 157, 2773, 1'b0);
        run_op("base_one", 1, 157, 2773, 1'b0);

        // Exponent zero and illegal operands.
        run_op("exp_zero", 5, 0, 2773, 1'b0);
        run_op("mod_one", 0, 157, 1, 1'b0);
        run_op("c_ge_n", 3000, 157, 2773, 1'b0);
        run_op("c_eq_n", 2773, 157, 2773, 1'b0);

        // Reset mid-operation, then a clean restart.
        start_op("abort", 948, 157, 2773);
        repeat (W + 10) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_message", 128'(bus.message), 128'(0));
        check("abort_err", 128'(bus.err), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_done", 128'(bus.done), 128'(0));
        run_op("after_abort", 948, 157, 2773, 1'b0);

        // Start toggled and operands changed while busy.
        run_op("disturbed", 948, 157, 2773, 1'b1);

        // Randomized operands.
        for (int i = 0; i < 8; i++) begin
            rn = longint'($urandom_range(2, 65535));
            rc = longint'($urandom_range(0, 65535)) % rn;
            rd = longint'($urandom_range(0, 4095));
            run_op($sformatf("rand%0d", i), rc, rd, rn, 1'b0);
        end

        // New operands after done: done clears, new result appears.
        run_op("final", 123, 45, 2773, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
